// File: rtl/timekeeper_hms.sv
// timekeeper_hms: prescaled hours/minutes/seconds clock with load, 12h/24h modes and optional alarm.
// Optional alarm compare is built only when TIMEKEEPER_ALARM_EN is defined.
`default_nettype none

module timekeeper_hms #(
  parameter int TICK_DIV = 50000000,
  parameter int H24      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_en,
  input  logic [4:0] set_h,
  input  logic [5:0] set_m,
  input  logic [5:0] set_s,
  input  logic       alarm_on,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       set_err,
  output logic       alarm_hit
);

  localparam int              c_PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICK_DIV - 1);
  localparam logic [4:0]      c_HRS_RST = (H24 != 0) ? 5'd0 : 5'd12;

  logic [c_PW-1:0] r_pre;
  logic [4:0]      r_hours;
  logic [5:0]      r_mins;
  logic [5:0]      r_secs;
  logic            r_pm;
  logic            r_tick;
  logic            r_wrap;
  logic            r_err;
  logic            r_alarm;

  logic            w_tick;
  logic            w_valid;
  logic            w_h_ok;
  logic [4:0]      w_h_nxt;
  logic [5:0]      w_m_nxt;
  logic [5:0]      w_s_nxt;
  logic            w_pm_nxt;
  logic            w_wrap;
  logic            w_alarm;

  assign w_tick  = run && (r_pre == c_PRE_MAX);
  assign w_h_ok  = (H24 != 0) ? (set_h <= 5'd23) : ((set_h >= 5'd1) && (set_h <= 5'd12));
  assign w_valid = w_h_ok && (set_m <= 6'd59) && (set_s <= 6'd59);

  always_comb begin
    w_s_nxt  = r_secs + 6'd1;
    w_m_nxt  = r_mins;
    w_h_nxt  = r_hours;
    w_pm_nxt = r_pm;
    w_wrap   = 1'b0;
    if (r_secs == 6'd59) begin
      w_s_nxt = 6'd0;
      w_m_nxt = r_mins + 6'd1;
      if (r_mins == 6'd59) begin
        w_m_nxt = 6'd0;
        if (H24 != 0) begin
          if (r_hours == 5'd23) begin
            w_h_nxt = 5'd0;
            w_wrap  = 1'b1;
          end else begin
            w_h_nxt = r_hours + 5'd1;
          end
        end else begin
          // 12h dial: 12 -> 1 ... 11 -> 12, with the meridiem flipping on 11 -> 12
          if (r_hours == 5'd12) begin
            w_h_nxt = 5'd1;
          end else if (r_hours == 5'd11) begin
            w_h_nxt  = 5'd12;
            w_pm_nxt = ~r_pm;
            w_wrap   = r_pm;
          end else begin
            w_h_nxt = r_hours + 5'd1;
          end
        end
      end
    end
  end

`ifdef TIMEKEEPER_ALARM_EN
  assign w_alarm = alarm_on && (w_s_nxt == 6'd0) && (w_m_nxt == alarm_m) && (w_h_nxt == alarm_h);
`else
  logic w_alarm_unused;
  assign w_alarm_unused = ^{alarm_on, alarm_h, alarm_m};
  assign w_alarm        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_hours <= c_HRS_RST;
      r_mins  <= 6'd0;
      r_secs  <= 6'd0;
      r_pm    <= 1'b0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_alarm <= 1'b0;
      if (set_en) begin
        // A load takes priority over any tick; a rejected load freezes everything for that cycle
        if (w_valid) begin
          r_pre   <= '0;
          r_hours <= set_h;
          r_mins  <= set_m;
          r_secs  <= set_s;
          r_pm    <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (run) begin
        if (w_tick) begin
          r_pre   <= '0;
          r_hours <= w_h_nxt;
          r_mins  <= w_m_nxt;
          r_secs  <= w_s_nxt;
          r_pm    <= w_pm_nxt;
          r_tick  <= 1'b1;
          r_wrap  <= w_wrap;
          r_alarm <= w_alarm;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end
    end
  end

  assign hours     = r_hours;
  assign mins      = r_mins;
  assign secs      = r_secs;
  assign pm        = r_pm;
  assign sec_tick  = r_tick;
  assign day_wrap  = r_wrap;
  assign set_err   = r_err;
  assign alarm_hit = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_timekeeper_hms.sv
// tb_timekeeper_hms: directed checks of a 24h instance (TICK_DIV=4) and a 12h instance (TICK_DIV=1).
`default_nettype none

module tb_timekeeper_hms;

`ifdef TIMEKEEPER_ALARM_EN
  localparam int c_ALARM = 1;
`else
  localparam int c_ALARM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       run24 = 1'b1, set_en24 = 1'b0, al_on = 1'b0;
  logic [4:0] set_h24 = '0, al_h = '0;
  logic [5:0] set_m24 = '0, set_s24 = '0, al_m = '0;
  logic [4:0] h24;
  logic [5:0] m24, s24;
  logic       pm24, tk24, dw24, er24, al24;

  logic       run12 = 1'b0, set_en12 = 1'b0;
  logic [4:0] set_h12 = '0;
  logic [5:0] set_m12 = '0, set_s12 = '0;
  logic [4:0] h12;
  logic [5:0] m12, s12;
  logic       pm12, tk12, dw12, er12, al12;

  timekeeper_hms #(.TICK_DIV(4), .H24(1)) u24 (
    .clk(clk), .rst(rst), .run(run24), .set_en(set_en24),
    .set_h(set_h24), .set_m(set_m24), .set_s(set_s24),
    .alarm_on(al_on), .alarm_h(al_h), .alarm_m(al_m),
    .hours(h24), .mins(m24), .secs(s24), .pm(pm24),
    .sec_tick(tk24), .day_wrap(dw24), .set_err(er24), .alarm_hit(al24)
  );

  timekeeper_hms #(.TICK_DIV(1), .H24(0)) u12 (
    .clk(clk), .rst(rst), .run(run12), .set_en(set_en12),
    .set_h(set_h12), .set_m(set_m12), .set_s(set_s12),
    .alarm_on(1'b0), .alarm_h(5'd0), .alarm_m(6'd0),
    .hours(h12), .mins(m12), .secs(s12), .pm(pm12),
    .sec_tick(tk12), .day_wrap(dw12), .set_err(er12), .alarm_hit(al12)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load24(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_h24 = h; set_m24 = m; set_s24 = s; set_en24 = 1'b1;
    step();
    set_en24 = 1'b0;
  endtask

  task automatic load12(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_h12 = h; set_m12 = m; set_s12 = s; set_en12 = 1'b1;
    step();
    set_en12 = 1'b0;
  endtask

  task automatic chk24(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, 32'(h24), 32'(h));
    check({tag, "_m"}, 32'(m24), 32'(m));
    check({tag, "_s"}, 32'(s24), 32'(s));
  endtask

  task automatic chk12(input string tag, input int h, input int m, input int s, input int p);
    check({tag, "_h"}, 32'(h12), 32'(h));
    check({tag, "_m"}, 32'(m12), 32'(m));
    check({tag, "_s"}, 32'(s12), 32'(s));
    check({tag, "_pm"}, 32'(pm12), 32'(p));
  endtask

  initial begin
    int bad_range;
    int wraps;

    // Reset values
    repeat (2) step();
    chk24("rst24", 0, 0, 0);
    check("rst24_tick", 32'(tk24), 0);
    check("rst24_pm", 32'(pm24), 0);
    chk12("rst12", 12, 0, 0, 0);

    // Free running from reset: tick every 4th cycle
    rst = 1'b1;
    for (int c = 1; c <= 960; c++) begin
      step();
      check("tick_period", 32'(tk24), (c % 4 == 0) ? 32'd1 : 32'd0);
      if (c == 240) chk24("t240", 0, 1, 0);
    end
    chk24("t960", 0, 4, 0);

    // Midnight rollover in 24h mode
    load24(5'd23, 6'd59, 6'd58);
    chk24("ld235958", 23, 59, 58);
    check("ld_notick", 32'(tk24), 0);
    repeat (4) step();
    chk24("t235959", 23, 59, 59);
    check("t235959_dw", 32'(dw24), 0);
    repeat (4) step();
    chk24("midnight", 0, 0, 0);
    check("midnight_dw", 32'(dw24), 1);
    check("midnight_tk", 32'(tk24), 1);
    check("pm24_held", 32'(pm24), 0);
    step();
    check("dw_pulse", 32'(dw24), 0);

    // Load coinciding with a prescaler terminal count
    repeat (2) step();
    load24(5'd10, 6'd20, 6'd30);
    chk24("ld_coinc", 10, 20, 30);
    check("ld_coinc_tk", 32'(tk24), 0);
    repeat (3) step();
    check("coinc_hold_s", 32'(s24), 30);
    step();
    check("coinc_next_s", 32'(s24), 31);
    check("coinc_next_tk", 32'(tk24), 1);

    // Rejected loads: time and prescaler untouched, one-cycle error pulse
    load24(5'd24, 6'd0, 6'd0);
    check("err24h", 32'(er24), 1);
    chk24("err24h_t", 10, 20, 31);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) check("err_pulse", 32'(er24), 0);
      check("err_pre_kept", 32'(tk24), (c == 4) ? 32'd1 : 32'd0);
    end
    load24(5'd10, 6'd60, 6'd0);
    check("err60m", 32'(er24), 1);
    chk24("err60m_t", 10, 20, 32);

    // run=0 freezes prescaler and time
    step();
    step();
    run24 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("frz_tick", 32'(tk24), 0);
    end
    chk24("frz_t", 10, 20, 32);
    run24 = 1'b1;
    step();
    check("resume_1", 32'(tk24), 0);
    step();
    check("resume_2", 32'(tk24), 1);
    check("resume_s", 32'(s24), 33);

    // Alarm on a ticked match only
    al_on = 1'b1; al_h = 5'd7; al_m = 6'd30;
    load24(5'd7, 6'd29, 6'd59);
    check("al_ld", 32'(al24), 0);
    repeat (4) step();
    chk24("al_t", 7, 30, 0);
    check("al_hit", 32'(al24), 32'(c_ALARM));
    step();
    check("al_pulse", 32'(al24), 0);
    load24(5'd7, 6'd30, 6'd0);
    check("al_direct_ld", 32'(al24), 0);
    al_on = 1'b0;

    // Asynchronous reset mid-count
    repeat (2) step();
    #3;
    rst = 1'b0;
    #1;
    chk24("arst", 0, 0, 0);
    check("arst_tk", 32'(tk24), 0);
    check("arst_al", 32'(al24), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("arst_restart", 32'(tk24), (c == 4) ? 32'd1 : 32'd0);
    end
    check("arst_s", 32'(s24), 1);

    // 12h mode
    run24 = 1'b0;
    run12 = 1'b1;
    load12(5'd0, 6'd0, 6'd0);
    check("err12_h0", 32'(er12), 1);
    chk12("err12_t", 12, 0, 0, 0);
    load12(5'd13, 6'd0, 6'd0);
    check("err12_h13", 32'(er12), 1);
    load12(5'd11, 6'd59, 6'd59);
    chk12("ld12", 11, 59, 59, 0);
    check("ld12_err", 32'(er12), 0);
    step();
    chk12("noon", 12, 0, 0, 1);
    check("noon_dw", 32'(dw12), 0);
    bad_range = 0;
    wraps = 0;
    for (int c = 1; c < 43200; c++) begin
      step();
      if (h12 < 5'd1 || h12 > 5'd12 || m12 > 6'd59 || s12 > 6'd59) bad_range++;
      if (dw12) wraps++;
      if (c == 3600) chk12("pm1", 1, 0, 0, 1);
    end
    check("range12", 32'(bad_range), 0);
    check("no_early_wrap", 32'(wraps), 0);
    chk12("pm1159", 11, 59, 59, 1);
    step();
    chk12("midnight12", 12, 0, 0, 0);
    check("midnight12_dw", 32'(dw12), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
